result_drain: RTL

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain.sv | 119 +++++++++++
 1 files changed

// File: rtl/result_drain.sv
// result_drain: pulls cfg_count words from the CNN result buffer into a FWFT FIFO.
// Optional RESULT_DRAIN_RELU_EN clamps negative words to zero on push.
module result_drain #(
  parameter int RESULT_BUFFER_WIDTH = 16,
  parameter int OUT_FIFO_DEPTH      = 4,
  parameter int COUNT_WIDTH         = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COUNT_WIDTH-1:0]         cfg_count,
  output logic                           busy,
  output logic                           done,
  input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
  input  logic                           result_buffer_empty,
  input  logic                           result_buffer_valid,
  output logic                           result_buffer_read_enable,
  output logic [RESULT_BUFFER_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    GAP,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [COUNT_WIDTH-1:0]         word_cnt;
  logic [COUNT_WIDTH-1:0]         cnt_lat;
  logic [AW-1:0]                  wr_ptr;
  logic [AW-1:0]                  rd_ptr;
  logic [OW-1:0]                  occ;
  logic [RESULT_BUFFER_WIDTH-1:0] mem [OUT_FIFO_DEPTH];
  logic [RESULT_BUFFER_WIDTH-1:0] push_data;
  logic                           push;
  logic                           pop;
  logic                           room;

  // Room is judged on registered occupancy only; a same-cycle pop never helps.
  assign room = occ < OW'(OUT_FIFO_DEPTH);
  assign push = (state == REQ) && result_buffer_valid;
  assign pop  = out_valid && out_ready;

  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign busy = (state == WAIT) || (state == REQ) || (state == GAP);
  assign done = (state == FIN);
  assign result_buffer_read_enable = (state == REQ);

`ifdef RESULT_DRAIN_RELU_EN
  assign push_data = result_buffer_out[RESULT_BUFFER_WIDTH-1] ?
                     '0 : result_buffer_out;
`else
  assign push_data = result_buffer_out;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = WAIT;
      WAIT: begin
        if (word_cnt == cnt_lat)
          state_nxt = FIN;
        else if (!result_buffer_empty && room)
          state_nxt = REQ;
      end
      REQ:  if (result_buffer_valid) state_nxt = GAP;
      GAP:  state_nxt = WAIT;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      cnt_lat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cnt_lat  <= cfg_count;
        word_cnt <= '0;
      end else if (push) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
